// File: rtl/load_buffer.sv
// In-order load buffer between address calculation and data memory.
// Issues one load at a time, formats returned data and holds it until the CDB takes it.
module load_buffer #(
  parameter int unsigned LB_DEPTH  = 4,
  parameter int unsigned ROB_IDX_W = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic                 acu_valid,
  input  logic [31:0]          acu_addr,
  input  logic [1:0]           acu_size,
  input  logic                 acu_signed,
  input  logic [ROB_IDX_W-1:0] acu_rob_idx,
  input  logic                 lb_exec_stall,
  input  logic                 mem_resp_valid,
  input  logic [63:0]          mem_rdata,
  input  logic                 lb_wr_written,
  output logic                 lb_full,
  output logic                 lb_read_mem,
  output logic [31:0]          lb_mem_addr,
  output logic                 lb_wr_valid,
  output logic [31:0]          lb_wr_value,
  output logic [ROB_IDX_W-1:0] lb_wr_rob_idx
);

  localparam int unsigned PtrW = $clog2(LB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(LB_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e               state;
  logic [31:0]          ent_addr   [LB_DEPTH];
  logic [1:0]           ent_size   [LB_DEPTH];
  logic                 ent_signed [LB_DEPTH];
  logic [ROB_IDX_W-1:0] ent_rob    [LB_DEPTH];
  logic [PtrW-1:0]      head;
  logic [PtrW-1:0]      tail;
  logic [CntW-1:0]      count;
  logic                 discard;

  // In-flight load: only what is needed to format the response.
  logic [2:0]           fl_off;
  logic [1:0]           fl_size;
  logic                 fl_signed;
  logic [ROB_IDX_W-1:0] fl_rob;

  logic        do_enq;
  logic        do_deq;
  logic        do_resp;
  logic [63:0] shifted;
  logic [31:0] fmt;

  assign lb_full     = (count == FullCnt);
  assign lb_read_mem = (state == StReq);
  assign lb_mem_addr = {ent_addr[head][31:3], 3'b000};

  always_comb begin
    do_enq  = acu_valid & ~lb_full;
    do_deq  = (state == StReq) & ~lb_exec_stall;
    do_resp = (state == StWait) & mem_resp_valid;
    shifted = mem_rdata >> {fl_off, 3'b000};
    fmt     = shifted[31:0];
    case (fl_size)
      2'd0:    fmt = {{24{fl_signed & shifted[7]}}, shifted[7:0]};
      2'd1:    fmt = {{16{fl_signed & shifted[15]}}, shifted[15:0]};
      default: fmt = shifted[31:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(LB_DEPTH); i++) begin
        ent_addr[i]   <= '0;
        ent_size[i]   <= '0;
        ent_signed[i] <= 1'b0;
        ent_rob[i]    <= '0;
      end
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      state         <= StIdle;
      discard       <= 1'b0;
      fl_off        <= '0;
      fl_size       <= '0;
      fl_signed     <= 1'b0;
      fl_rob        <= '0;
      lb_wr_valid   <= 1'b0;
      lb_wr_value   <= '0;
      lb_wr_rob_idx <= '0;
    end else if (squash) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      state       <= StIdle;
      lb_wr_valid <= 1'b0;
      // A request still owed by memory must have its response swallowed.
      discard     <= ((discard | (state == StWait)) & ~mem_resp_valid) | do_deq;
    end else begin
      if (do_enq) begin
        ent_addr[tail]   <= acu_addr;
        ent_size[tail]   <= acu_size;
        ent_signed[tail] <= acu_signed;
        ent_rob[tail]    <= acu_rob_idx;
        tail             <= tail + PtrW'(1);
      end
      if (do_deq) begin
        fl_off    <= ent_addr[head][2:0];
        fl_size   <= ent_size[head];
        fl_signed <= ent_signed[head];
        fl_rob    <= ent_rob[head];
        head      <= head + PtrW'(1);
      end
      count <= count + CntW'(do_enq) - CntW'(do_deq);
      if (discard && mem_resp_valid) discard <= 1'b0;

      case (state)
        StIdle:  if (count != '0 && !discard) state <= StReq;
        StReq:   if (!lb_exec_stall) state <= StWait;
        StWait:  if (mem_resp_valid) state <= StIdle;
        default: state <= StIdle;
      endcase

      // A new result wins over a same-cycle consume of the old one.
      if (do_resp) begin
        lb_wr_valid   <= 1'b1;
        lb_wr_value   <= fmt;
        lb_wr_rob_idx <= fl_rob;
      end else if (lb_wr_written) begin
        lb_wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer: scoreboard of expected write-back results,
// a 1-cycle data memory model and a CDB consumer that can be held off.
module tb_load_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        squash;
  logic        acu_valid;
  logic [31:0] acu_addr;
  logic [1:0]  acu_size;
  logic        acu_signed;
  logic [4:0]  acu_rob_idx;
  logic        lb_exec_stall;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;
  logic        lb_wr_written;
  logic        lb_full;
  logic        lb_read_mem;
  logic [31:0] lb_mem_addr;
  logic        lb_wr_valid;
  logic [31:0] lb_wr_value;
  logic [4:0]  lb_wr_rob_idx;

  logic stall_force = 1'b0;
  logic hold        = 1'b0;
  logic mem_hold    = 1'b0;
  logic        resp_pending = 1'b0;
  logic [31:0] resp_addr    = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] val;
    logic [4:0]  rob;
  } sb_entry_t;
  sb_entry_t sb[$];

  logic [63:0] mem [int unsigned];

  // Hazard unit stand-in: an unconsumed result blocks new requests.
  assign lb_exec_stall = stall_force | (lb_wr_valid & hold);

  load_buffer #(.LB_DEPTH(4), .ROB_IDX_W(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .acu_valid     (acu_valid),
    .acu_addr      (acu_addr),
    .acu_size      (acu_size),
    .acu_signed    (acu_signed),
    .acu_rob_idx   (acu_rob_idx),
    .lb_exec_stall (lb_exec_stall),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata),
    .lb_wr_written (lb_wr_written),
    .lb_full       (lb_full),
    .lb_read_mem   (lb_read_mem),
    .lb_mem_addr   (lb_mem_addr),
    .lb_wr_valid   (lb_wr_valid),
    .lb_wr_value   (lb_wr_value),
    .lb_wr_rob_idx (lb_wr_rob_idx)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    int unsigned k = a >> 3;
    return mem.exists(k) ? mem[k] : 64'h0;
  endfunction

  // Reference formatter built byte by byte.
  function automatic logic [31:0] ref_fmt(input logic [63:0] dw, input logic [2:0] off,
                                          input logic [1:0] sz, input logic sg);
    int n;
    logic [31:0] r;
    logic msb;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = dw[8*(int'(off) + i) +: 8];
    msb = r[8*n-1];
    for (int i = n; i < 4; i++) r[8*i +: 8] = {8{sg & msb}};
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                     input logic [4:0] rob);
    sb_entry_t e;
    acu_valid   = 1'b1;
    acu_addr    = a;
    acu_size    = sz;
    acu_signed  = sg;
    acu_rob_idx = rob;
    if (!lb_full) begin
      e.val = ref_fmt(mem_rd(a), a[2:0], sz, sg);
      e.rob = rob;
      sb.push_back(e);
    end
    step();
    acu_valid = 1'b0;
  endtask

  task automatic wait_not_full();
    int n = 0;
    while (lb_full && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL not_full_timeout: lb_full still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || lb_wr_valid) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $error("FAIL %s: %0d results outstanding after timeout, required 0", tag, sb.size());
    end
  endtask

  // Data memory: captures an accepted request, answers on the following cycle.
  always @(negedge clock) begin
    mem_resp_valid = 1'b0;
    if (!reset) begin
      if (resp_pending && !mem_hold) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = mem_rd(resp_addr);
        resp_pending   = 1'b0;
      end
      if (lb_read_mem && !lb_exec_stall) begin
        resp_pending = 1'b1;
        resp_addr    = lb_mem_addr;
      end
    end
  end

  // CDB consumer: takes and scores each result unless held off.
  always @(negedge clock) begin
    sb_entry_t e;
    lb_wr_written = 1'b0;
    if (!reset && lb_wr_valid && !hold) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_result: observed value %0h tag %0d, expected no result",
               lb_wr_value, lb_wr_rob_idx);
      end else begin
        e = sb.pop_front();
        check("wb_value", 64'(lb_wr_value), 64'(e.val));
        check("wb_tag", 64'(lb_wr_rob_idx), 64'(e.rob));
      end
      lb_wr_written = 1'b1;
    end
  end

  initial begin
    reset       = 1'b1;
    squash      = 1'b0;
    acu_valid   = 1'b0;
    acu_addr    = '0;
    acu_size    = '0;
    acu_signed  = 1'b0;
    acu_rob_idx = '0;
    mem_rdata   = '0;
    lb_wr_written = 1'b0;
    mem[32'h1000 >> 3] = 64'h0102_0304_80AA_BBCC;
    mem[32'h3000 >> 3] = 64'h8877_6655_4433_2211;
    mem[32'h4000 >> 3] = 64'hCAFE_F00D_1234_5678;
    mem[32'h5000 >> 3] = 64'h0000_0000_0000_00A5;
    mem[32'h6000 >> 3] = 64'h0000_0000_0000_7E3C;
    mem[32'h2000 >> 3] = 64'hBEEF_0000_0000_0000;
    step();
    step();
    check("rst_full", 64'(lb_full), 64'h0);
    check("rst_read_mem", 64'(lb_read_mem), 64'h0);
    check("rst_mem_addr", 64'(lb_mem_addr), 64'h0);
    check("rst_wr_valid", 64'(lb_wr_valid), 64'h0);
    check("rst_wr_value", 64'(lb_wr_value), 64'h0);
    check("rst_wr_rob", 64'(lb_wr_rob_idx), 64'h0);
    reset = 1'b0;
    step();

    // Single signed byte load and its latency.
    enq(32'h1003, 2'd0, 1'b1, 5'd7);
    check("t1_read_mem_t1", 64'(lb_read_mem), 64'h0);
    step();
    check("t1_read_mem_t2", 64'(lb_read_mem), 64'h1);
    check("t1_mem_addr", 64'(lb_mem_addr), 64'h1000);
    step();
    check("t1_read_mem_t3", 64'(lb_read_mem), 64'h0);
    check("t1_wr_valid_t3", 64'(lb_wr_valid), 64'h0);
    step();
    check("t1_wr_valid_t4", 64'(lb_wr_valid), 64'h1);
    check("t1_wr_value", 64'(lb_wr_value), 64'hFFFF_FF80);
    check("t1_wr_rob", 64'(lb_wr_rob_idx), 64'd7);
    drain("t1_drain");

    // Fill under stall; fifth load is dropped; stall holds head in REQ.
    stall_force = 1'b1;
    enq(32'h3000, 2'd0, 1'b0, 5'd1);
    enq(32'h3002, 2'd1, 1'b1, 5'd2);
    enq(32'h3004, 2'd2, 1'b0, 5'd3);
    check("t2_not_full_at_3", 64'(lb_full), 64'h0);
    enq(32'h3007, 2'd0, 1'b1, 5'd4);
    check("t2_full", 64'(lb_full), 64'h1);
    enq(32'h3001, 2'd0, 1'b0, 5'd31);
    check("t2_full_after_5th", 64'(lb_full), 64'h1);
    for (int i = 0; i < 3; i++) begin
      check("t3_read_mem_stalled", 64'(lb_read_mem), 64'h1);
      check("t3_head_addr", 64'(lb_mem_addr), 64'h3000);
      step();
    end
    stall_force = 1'b0;
    step();
    check("t3_wait_after_release", 64'(lb_read_mem), 64'h0);
    check("t3_full_after_pop", 64'(lb_full), 64'h0);
    drain("t2_drain");

    // Unconsumed result blocks the next load from leaving REQ.
    hold = 1'b1;
    enq(32'h4000, 2'd2, 1'b0, 5'd9);
    enq(32'h4005, 2'd0, 1'b1, 5'd10);
    begin
      int n = 0;
      while (!lb_wr_valid && n < 20) begin
        step();
        n++;
      end
    end
    step();
    for (int i = 0; i < 3; i++) begin
      check("t4_wr_valid_held", 64'(lb_wr_valid), 64'h1);
      check("t4_wr_value_held", 64'(lb_wr_value), 64'h1234_5678);
      check("t4_read_mem_blocked", 64'(lb_read_mem), 64'h1);
      step();
    end
    hold = 1'b0;
    drain("t4_drain");

    // Squash while a request is outstanding: its late response must vanish.
    mem_hold = 1'b1;
    enq(32'h5000, 2'd0, 1'b1, 5'd20);
    enq(32'h5000, 2'd0, 1'b0, 5'd21);
    enq(32'h5000, 2'd1, 1'b0, 5'd22);
    check("t5_in_wait", 64'(lb_read_mem), 64'h0);
    squash = 1'b1;
    step();
    squash = 1'b0;
    sb.delete();
    check("t5_wr_valid_clear", 64'(lb_wr_valid), 64'h0);
    check("t5_not_full", 64'(lb_full), 64'h0);
    enq(32'h6001, 2'd0, 1'b1, 5'd23);
    step();
    check("t5_no_req_while_discard", 64'(lb_read_mem), 64'h0);
    mem_hold = 1'b0;
    step();
    step();
    check("t5_wr_valid_after_stale", 64'(lb_wr_valid), 64'h0);
    drain("t5_drain");

    // Wrap the pointers with six unsigned halfword loads, checked in tag order.
    for (int i = 0; i < 6; i++) begin
      wait_not_full();
      enq(32'h2006, 2'd1, 1'b0, 5'(10 + i));
    end
    drain("t6_drain");
    check("t6_expected_value", 64'(ref_fmt(mem_rd(32'h2006), 3'd6, 2'd1, 1'b0)), 64'h0000_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
